gshare_predictor: RTL and testbench



---
 rtl/gshare_predictor_if.sv | 36 +++
 rtl/gshare_predictor.sv | 160 ++++++++++++++++
 tb/tb_gshare_predictor.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/gshare_predictor_if.sv
// Bundles the fetch request, prediction response, speculative history and EX training/repair signals
// exchanged with the gshare predictor.
interface gshare_predictor_if #(
  parameter int unsigned GHR_WIDTH = 8
) ();

  logic                 init_done;
  logic                 if1_valid;
  logic [31:0]          if1_pc;
  logic                 pred_valid;
  logic                 pred_taken;
  logic [GHR_WIDTH-1:0] pred_idx;
  logic [GHR_WIDTH-1:0] pred_ghr;
  logic                 spec_upd;
  logic                 spec_taken;
  logic                 ex_we;
  logic [GHR_WIDTH-1:0] ex_idx;
  logic                 ex_taken;
  logic                 ex_mispredict;
  logic [GHR_WIDTH-1:0] ex_ghr;

  // Pipeline side: issues requests, history updates and training.
  modport master (
    input  init_done, pred_valid, pred_taken, pred_idx, pred_ghr,
    output if1_valid, if1_pc, spec_upd, spec_taken,
    output ex_we, ex_idx, ex_taken, ex_mispredict, ex_ghr
  );

  // Predictor side.
  modport slave (
    output init_done, pred_valid, pred_taken, pred_idx, pred_ghr,
    input  if1_valid, if1_pc, spec_upd, spec_taken,
    input  ex_we, ex_idx, ex_taken, ex_mispredict, ex_ghr
  );

endinterface

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: speculative GHR, PHT of saturating counters, post-reset sweep clear.
// Define GSHARE_BYPASS_EN to forward a same-cycle training write into the prediction.
module gshare_predictor #(
  parameter int unsigned GHR_WIDTH = 8,
  parameter int unsigned CTR_WIDTH = 2,
  parameter int unsigned PC_LSB    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  gshare_predictor_if.slave  bp
);

  localparam int unsigned           DEPTH    = 1 << GHR_WIDTH;
  localparam logic [GHR_WIDTH-1:0]  PTR_LAST = '1;
  localparam logic [CTR_WIDTH-1:0]  CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0]  CTR_MIN  = '0;
  localparam logic [CTR_WIDTH-1:0]  WEAK_NT  = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]           r_state;
  logic [0:0]           w_state_nxt;
  logic [GHR_WIDTH-1:0] r_ptr;
  logic [GHR_WIDTH-1:0] w_ptr_nxt;
  logic                 w_run;

  logic [CTR_WIDTH-1:0] r_pht [DEPTH];
  logic                 w_pht_we;
  logic [GHR_WIDTH-1:0] w_pht_waddr;
  logic [CTR_WIDTH-1:0] w_pht_wdata;

  logic [GHR_WIDTH-1:0] r_ghr;
  logic [GHR_WIDTH-1:0] w_ghr_nxt;
  logic [GHR_WIDTH-1:0] w_idx;
  logic [CTR_WIDTH-1:0] w_ex_ctr;
  logic [CTR_WIDTH-1:0] w_ex_ctr_upd;
  logic [CTR_WIDTH-1:0] w_pred_ctr;

  logic                 r_init_done;
  logic                 r_pred_valid;
  logic                 r_pred_taken;
  logic [GHR_WIDTH-1:0] r_pred_idx;
  logic [GHR_WIDTH-1:0] r_pred_ghr;

  logic                 w_unused_bits;

  assign w_unused_bits = ^{bp.if1_pc, bp.ex_ghr};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next state and PHT write-port arbitration: sweep owns the port in INIT, training in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_run       = 1'b0;
    w_pht_we    = 1'b0;
    w_pht_waddr = bp.ex_idx;
    w_pht_wdata = w_ex_ctr_upd;
    case (r_state)
      S_INIT: begin
        w_pht_we    = 1'b1;
        w_pht_waddr = r_ptr;
        w_pht_wdata = WEAK_NT;
        w_ptr_nxt   = r_ptr + GHR_WIDTH'(1);
        if (r_ptr == PTR_LAST) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_run    = 1'b1;
        w_pht_we = bp.ex_we;
      end
      default: begin
        w_state_nxt = S_INIT;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // Saturating counter update for the entry being trained.
  always_comb begin
    w_ex_ctr     = r_pht[bp.ex_idx];
    w_ex_ctr_upd = w_ex_ctr;
    if (bp.ex_taken) begin
      if (w_ex_ctr != CTR_MAX) begin
        w_ex_ctr_upd = w_ex_ctr + CTR_WIDTH'(1);
      end
    end else begin
      if (w_ex_ctr != CTR_MIN) begin
        w_ex_ctr_upd = w_ex_ctr - CTR_WIDTH'(1);
      end
    end
  end

  assign w_idx = r_ghr ^ bp.if1_pc[PC_LSB+GHR_WIDTH-1:PC_LSB];

`ifdef GSHARE_BYPASS_EN
  assign w_pred_ctr = (w_run && bp.ex_we && (bp.ex_idx == w_idx)) ? w_ex_ctr_upd : r_pht[w_idx];
`else
  assign w_pred_ctr = r_pht[w_idx];
`endif

  // Repair from EX outranks the speculative shift from IF.
  always_comb begin
    w_ghr_nxt = r_ghr;
    if (w_run) begin
      if (bp.ex_mispredict) begin
        w_ghr_nxt = {bp.ex_ghr[GHR_WIDTH-2:0], bp.ex_taken};
      end else if (bp.spec_upd) begin
        w_ghr_nxt = {r_ghr[GHR_WIDTH-2:0], bp.spec_taken};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_pht_we && rst_n) begin
      r_pht[w_pht_waddr] <= w_pht_wdata;
    end
  end

  // History, prediction outputs and init flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ghr        <= '0;
      r_init_done  <= 1'b0;
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_idx   <= '0;
      r_pred_ghr   <= '0;
    end else begin
      r_ghr        <= w_ghr_nxt;
      r_init_done  <= (r_state == S_RUN);
      r_pred_valid <= w_run && bp.if1_valid;
      if (w_run) begin
        r_pred_taken <= w_pred_ctr[CTR_WIDTH-1];
      end
      if (w_run && bp.if1_valid) begin
        r_pred_idx <= w_idx;
        r_pred_ghr <= r_ghr;
      end
    end
  end

  assign bp.init_done  = r_init_done;
  assign bp.pred_valid = r_pred_valid;
  assign bp.pred_taken = r_pred_taken;
  assign bp.pred_idx   = r_pred_idx;
  assign bp.pred_ghr   = r_pred_ghr;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor at GHR_WIDTH=4, CTR_WIDTH=2, PC_LSB=2.
module tb_gshare_predictor;

  localparam int unsigned GW = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  gshare_predictor_if #(.GHR_WIDTH(GW)) bp ();

  gshare_predictor #(.GHR_WIDTH(GW), .CTR_WIDTH(2), .PC_LSB(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] pc);
    bp.if1_valid = 1'b1;
    bp.if1_pc    = pc;
    tick();
    bp.if1_valid = 1'b0;
  endtask

  task automatic train(input logic [GW-1:0] idx, input logic taken);
    bp.ex_we    = 1'b1;
    bp.ex_idx   = idx;
    bp.ex_taken = taken;
    tick();
    bp.ex_we    = 1'b0;
  endtask

  task automatic spec(input logic taken);
    bp.spec_upd   = 1'b1;
    bp.spec_taken = taken;
    tick();
    bp.spec_upd   = 1'b0;
  endtask

  logic       tr_dir [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       tr_exp [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       exp_byp;
  logic       seen_done;

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bp.if1_valid = 1'b0;
    bp.if1_pc = '0;
    bp.spec_upd = 1'b0;
    bp.spec_taken = 1'b0;
    bp.ex_we = 1'b0;
    bp.ex_idx = '0;
    bp.ex_taken = 1'b0;
    bp.ex_mispredict = 1'b0;
    bp.ex_ghr = '0;

    tick();
    chk("rst_init_done", 32'(bp.init_done), 32'd0);
    chk("rst_pred_valid", 32'(bp.pred_valid), 32'd0);
    chk("rst_pred_taken", 32'(bp.pred_taken), 32'd0);
    chk("rst_pred_idx", 32'(bp.pred_idx), 32'd0);
    chk("rst_pred_ghr", 32'(bp.pred_ghr), 32'd0);

    // Sweep with every input active: all must be ignored.
    rst_n = 1'b1;
    bp.if1_valid = 1'b1;
    bp.if1_pc = 32'h10;
    bp.spec_upd = 1'b1;
    bp.spec_taken = 1'b1;
    bp.ex_we = 1'b1;
    bp.ex_idx = 4'd4;
    bp.ex_taken = 1'b1;
    bp.ex_mispredict = 1'b1;
    bp.ex_ghr = 4'hF;
    seen_done = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bp.init_done || bp.pred_valid) seen_done = 1'b1;
    end
    chk("sweep_quiet_16", 32'(seen_done), 32'd0);
    bp.if1_valid = 1'b0;
    bp.spec_upd = 1'b0;
    bp.ex_we = 1'b0;
    bp.ex_mispredict = 1'b0;
    tick();
    chk("init_done_edge17", 32'(bp.init_done), 32'd1);

    req(32'h10);
    chk("first_valid", 32'(bp.pred_valid), 32'd1);
    chk("first_idx", 32'(bp.pred_idx), 32'd4);
    chk("first_ghr", 32'(bp.pred_ghr), 32'd0);
    chk("first_taken", 32'(bp.pred_taken), 32'd0);
    tick();
    chk("idle_valid", 32'(bp.pred_valid), 32'd0);
    chk("idle_idx_hold", 32'(bp.pred_idx), 32'd4);

    for (int k = 0; k < 16; k++) begin
      req(32'(k) << 2);
      chk($sformatf("sweep_idx_%0d", k), 32'(bp.pred_idx), 32'(k));
      chk($sformatf("sweep_weak_nt_%0d", k), 32'(bp.pred_taken), 32'd0);
    end

    // Counter at idx 4: up to saturation, down to saturation, one up.
    for (int s = 0; s < 8; s++) begin
      train(4'd4, tr_dir[s]);
      req(32'h10);
      chk($sformatf("train_step_%0d", s), 32'(bp.pred_taken), 32'(tr_exp[s]));
    end

    // Build GHR = 1010 via speculative shifts.
    spec(1'b1);
    spec(1'b0);
    spec(1'b1);
    spec(1'b0);
    req(32'h0);
    chk("ghr_1010", 32'(bp.pred_ghr), 32'hA);
    chk("idx_ghr_xor", 32'(bp.pred_idx), 32'hA);

    bp.spec_upd = 1'b1;
    bp.spec_taken = 1'b1;
    bp.ex_mispredict = 1'b1;
    bp.ex_ghr = 4'b0011;
    bp.ex_taken = 1'b0;
    tick();
    bp.spec_upd = 1'b0;
    bp.ex_mispredict = 1'b0;
    req(32'h0);
    chk("repair_priority", 32'(bp.pred_ghr), 32'h6);

    // Prediction index uses GHR before the same-edge shift.
    bp.spec_upd = 1'b1;
    bp.spec_taken = 1'b1;
    req(32'h0);
    bp.spec_upd = 1'b0;
    chk("pre_shift_ghr", 32'(bp.pred_ghr), 32'h6);
    req(32'h0);
    chk("post_shift_ghr", 32'(bp.pred_ghr), 32'hD);

    // GHR=1101, pc slice 1000 -> idx 5, counter 01, train taken on the same edge.
`ifdef GSHARE_BYPASS_EN
    exp_byp = 1'b1;
`else
    exp_byp = 1'b0;
`endif
    bp.ex_we = 1'b1;
    bp.ex_idx = 4'd5;
    bp.ex_taken = 1'b1;
    req(32'h20);
    bp.ex_we = 1'b0;
    chk("same_idx_idx", 32'(bp.pred_idx), 32'd5);
    chk("same_idx_taken", 32'(bp.pred_taken), 32'(exp_byp));
    req(32'h20);
    chk("same_idx_after", 32'(bp.pred_taken), 32'd1);

    // Reset, release, reset again at sweep cycle 7.
    rst_n = 1'b0;
    tick();
    chk("rerst_pred_valid", 32'(bp.pred_valid), 32'd0);
    chk("rerst_init_done", 32'(bp.init_done), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bp.init_done) seen_done = 1'b1;
    end
    chk("restart_quiet_16", 32'(seen_done), 32'd0);
    tick();
    chk("restart_done", 32'(bp.init_done), 32'd1);
    req(32'h14);
    chk("restart_idx5", 32'(bp.pred_idx), 32'd5);
    chk("restart_ghr0", 32'(bp.pred_ghr), 32'd0);
    chk("restart_cleared", 32'(bp.pred_taken), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
